// File: rtl/mult_seq_pkg.sv
// Shared state encoding and elaboration-time helpers for the sequential slice multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    function automatic int unsigned num_pairs(input int unsigned na, input int unsigned nb);
        return na * nb;
    endfunction

    // Counter width that stays legal when only one slice exists.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned shift_amt(input int unsigned i, input int unsigned j,
                                              input int unsigned a_slice, input int unsigned b_slice);
        return i * a_slice + j * b_slice;
    endfunction

endpackage

// File: rtl/mult_seq_param_slice_mult.sv
// Combinational unsigned A_SLICE x B_SLICE partial-product multiplier.
module slice_mult #(
    parameter int unsigned A_SLICE = 16,
    parameter int unsigned B_SLICE = 8
) (
    input  logic [A_SLICE-1:0]         x,
    input  logic [B_SLICE-1:0]         y,
    output logic [A_SLICE+B_SLICE-1:0] p_c
);

    localparam int unsigned SW = A_SLICE + B_SLICE;

    assign p_c = SW'(x) * SW'(y);

endmodule

// File: rtl/mult_seq_param.sv
// Sequential multiplier: one slice partial product per clock into a full-width accumulator,
// with signed/unsigned mode handled by magnitude capture and a final conditional negate.
module mult_seq_param
    import mult_seq_pkg::*;
#(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned B_WIDTH = 32,
    parameter int unsigned A_SLICE = 16,
    parameter int unsigned B_SLICE = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       is_signed,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       busy,
    output logic                       done,
    output logic [A_WIDTH+B_WIDTH-1:0] product
);

    localparam int unsigned NA = num_slices(A_WIDTH, A_SLICE);
    localparam int unsigned NB = num_slices(B_WIDTH, B_SLICE);
    localparam int unsigned P  = num_pairs(NA, NB);
    localparam int unsigned PW = A_WIDTH + B_WIDTH;
    localparam int unsigned SW = A_SLICE + B_SLICE;
    localparam int unsigned IW = cnt_width(NA);
    localparam int unsigned JW = cnt_width(NB);

    if ((A_WIDTH % A_SLICE) != 0 || (B_WIDTH % B_SLICE) != 0 || P == 0) begin : g_bad_width
        $error("mult_seq_param: operand widths must be non-zero multiples of slice widths");
    end

    state_t             state, state_n;
    logic [A_WIDTH-1:0] a_mag, a_mag_n;
    logic [B_WIDTH-1:0] b_mag, b_mag_n;
    logic               neg, neg_n;
    logic [PW-1:0]      acc, acc_n;
    logic [IW-1:0]      i, i_n;
    logic [JW-1:0]      j, j_n;
    logic               busy_n, done_n;
    logic [PW-1:0]      product_n;
    logic [A_SLICE-1:0] a_slice;
    logic [B_SLICE-1:0] b_slice;
    logic [SW-1:0]      pp;

    assign a_slice = a_mag[32'(i) * A_SLICE +: A_SLICE];
    assign b_slice = b_mag[32'(j) * B_SLICE +: B_SLICE];

    slice_mult #(
        .A_SLICE(A_SLICE),
        .B_SLICE(B_SLICE)
    ) u_slice_mult (
        .x  (a_slice),
        .y  (b_slice),
        .p_c(pp)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_mag   <= '0;
            b_mag   <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state   <= state_n;
            a_mag   <= a_mag_n;
            b_mag   <= b_mag_n;
            neg     <= neg_n;
            acc     <= acc_n;
            i       <= i_n;
            j       <= j_n;
            busy    <= busy_n;
            done    <= done_n;
            product <= product_n;
        end
    end

    // Next-state and next-register logic; j is the inner slice index.
    always_comb begin
        state_n   = state;
        a_mag_n   = a_mag;
        b_mag_n   = b_mag;
        neg_n     = neg;
        acc_n     = acc;
        i_n       = i;
        j_n       = j;
        busy_n    = busy;
        done_n    = 1'b0;
        product_n = product;
        case (state)
            IDLE: begin
                if (start) begin
                    a_mag_n = (is_signed && a[A_WIDTH-1]) ? -a : a;
                    b_mag_n = (is_signed && b[B_WIDTH-1]) ? -b : b;
                    neg_n   = is_signed & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
                    acc_n   = '0;
                    i_n     = '0;
                    j_n     = '0;
                    busy_n  = 1'b1;
                    state_n = MUL;
                end
            end
            MUL: begin
                acc_n = acc + (PW'(pp) << shift_amt(32'(i), 32'(j), A_SLICE, B_SLICE));
                if (j == JW'(NB - 1)) begin
                    j_n = '0;
                    if (i == IW'(NA - 1)) begin
                        state_n = FIX;
                    end else begin
                        i_n = i + 1'b1;
                    end
                end else begin
                    j_n = j + 1'b1;
                end
            end
            FIX: begin
                product_n = neg ? -acc : acc;
                done_n    = 1'b1;
                busy_n    = 1'b0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/mult_seq_param.md
# mult_seq_param

Parametrised sequential multiplier: the generalised successor of the fixed 32x32 multiply FSM. It multiplies an A_WIDTH x B_WIDTH operand pair by iterating one A_SLICE x B_SLICE partial product per clock, shifting each into an accumulator. It adds selectable signed/unsigned mode and a registered done pulse. It sits in the arithmetic datapath behind a start/busy/done handshake driven by the owning controller.

## Interface
- A_WIDTH, 32, multiplicand width; must be a multiple of A_SLICE
- B_WIDTH, 32, multiplier width; must be a multiple of B_SLICE
- A_SLICE, 16, multiplicand slice width of the partial multiplier
- B_SLICE, 8, multiplier slice width of the partial multiplier
- Derived: NA=A_WIDTH/A_SLICE, NB=B_WIDTH/B_SLICE, P=NA*NB (default 8)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when busy=0
- is_signed  in  1  1: two's-complement operands/result; 0: unsigned; captured with start
- a  in  A_WIDTH  multiplicand, captured with start
- b  in  B_WIDTH  multiplier, captured with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: product holds a new result
- product  out  A_WIDTH+B_WIDTH  result, held until the next done

## Operation
- States (shared enum): IDLE, MUL, FIX.
- IDLE: on start=1: capture magnitude |a|, |b| (two's-complement negate when is_signed and MSB=1; unsigned otherwise), neg = is_signed & (a[MSB]^b[MSB]); clear accumulator, i=0, j=0; -> MUL; busy<=1.
- MUL: each cycle acc += (a_mag slice i * b_mag slice j) << (i*A_SLICE + j*B_SLICE); j is inner index (0..NB-1), then i (0..NA-1). After pair (NA-1, NB-1) -> FIX.
- FIX: product <= neg ? -acc : acc; done<=1; busy<=0; -> IDLE.
- Magnitudes stored unsigned at full operand width; most-negative inputs are exact (-2^31 * -2^31 = 2^62; -2^31 * 1 = 0xFFFFFFFF80000000).
- Accumulator is A_WIDTH+B_WIDTH bits; no overflow possible.
- start while busy=1: ignored; captured operands unaffected.
- a, b, is_signed may change freely after the capture edge.

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE, accumulator and counters 0.
- Capture edge E0 (start=1, busy=0). busy=1 after E0.
- MUL edges E1..EP; FIX edge EP+1: product valid, done=1, busy=0 for the cycle after EP+1.
- Latency start-edge to done: P+1 cycles (9 at defaults). Fixed, independent of operand values and mode.
- done lasts exactly one cycle; busy and done never both 1.
- Back-to-back: start=1 in the done cycle is accepted (busy=0); the next done follows P+1 cycles later.
- Reset mid-operation: the next edge aborts to IDLE with reset values; no done; product cleared to 0.
- reset and start together: reset wins.

## Structure
- Package mult_seq_pkg: state enum typedef (IDLE, MUL, FIX). Helper constant functions for NA, NB, P, and shift amount from (i, j).
- Sub-module slice_mult: combinational A_SLICE x B_SLICE unsigned multiplier producing A_SLICE+B_SLICE bits. It is instantiated once.
- Top holds the FSM, slice muxes, shifter/accumulator, sign capture and final negate.
- Elaboration-time assertion on the divisibility of the widths.

## Test plan
- Reset held 4 cycles, then released -> busy=0, done=0, product=0; no spontaneous done.
- Unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle -> busy high 9 cycles; done at cycle 9; product=0xFFFFFFFE00000001.
- Signed: a=-3 (0xFFFFFFFD), b=7 -> product=0xFFFFFFFFFFFFFFEB (-21). Same operands with is_signed=0 -> 0x00000006FFFFFFEB.
- Signed extremes: a=b=0x80000000 -> 0x4000000000000000. a=0x80000000, b=1 -> 0xFFFFFFFF80000000.
- start pulsed at cycle 3 of a running op with different operands -> ignored, first result unchanged. New start in the done cycle -> second done exactly 9 cycles later.
- Reset asserted at cycle 5 of an op -> no done; product=0; a new op after release completes normally. A second configuration (A_WIDTH=16, B_WIDTH=8, A_SLICE=8, B_SLICE=4; P=4) checked against a reference model over 1000 random signed/unsigned vectors with latency 5.
